// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the main-memory bus arbiter: FSM states,
// owner encoding and the word-counter helper.
package mem_arb_pkg;

    localparam int WORD_SIZE = 16;
    localparam int CNT_W     = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        IC_XFER  = 3'd1,
        DC_XFER  = 3'd2,
        DMA_OWN  = 3'd3,
        DMA_XFER = 3'd4
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IC   = 2'd1,
        OWN_DC   = 2'd2,
        OWN_DMA  = 2'd3
    } owner_e;

    // DMA word counter stops at its maximum instead of wrapping back through the burst value
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == {CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_arb_mux.sv
// Selects the address, write enable and write data of the requester being
// launched onto the memory port.
module mem_arb_mux
    import mem_arb_pkg::*;
(
    input  logic [1:0]           sel,
    input  logic [WORD_SIZE-1:0] ic_addr,
    input  logic                 dc_we,
    input  logic [WORD_SIZE-1:0] dc_addr,
    input  logic [WORD_SIZE-1:0] dc_wdata,
    input  logic                 dma_we,
    input  logic [WORD_SIZE-1:0] dma_addr,
    input  logic [WORD_SIZE-1:0] dma_wdata,
    output logic [WORD_SIZE-1:0] sel_addr,
    output logic                 sel_we,
    output logic [WORD_SIZE-1:0] sel_wdata
);

    // Owner-indexed field select; the I-cache only ever reads
    always_comb begin
        sel_addr  = {WORD_SIZE{1'b0}};
        sel_we    = 1'b0;
        sel_wdata = {WORD_SIZE{1'b0}};
        case (owner_e'(sel))
            OWN_IC: begin
                sel_addr = ic_addr;
            end
            OWN_DC: begin
                sel_addr  = dc_addr;
                sel_we    = dc_we;
                sel_wdata = dc_wdata;
            end
            OWN_DMA: begin
                sel_addr  = dma_addr;
                sel_we    = dma_we;
                sel_wdata = dma_wdata;
            end
            default: begin
                sel_addr  = {WORD_SIZE{1'b0}};
                sel_we    = 1'b0;
                sel_wdata = {WORD_SIZE{1'b0}};
            end
        endcase
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbiter for the shared main-memory port: per-word cache grants and a
// bus-request/bus-grant DMA tenure preempted at burst boundaries.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned DMA_BURST = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ic_req,
    input  logic [WORD_SIZE-1:0] ic_addr,
    output logic [WORD_SIZE-1:0] ic_rdata,
    output logic                 ic_ack,
    input  logic                 dc_req,
    input  logic                 dc_we,
    input  logic [WORD_SIZE-1:0] dc_addr,
    input  logic [WORD_SIZE-1:0] dc_wdata,
    output logic [WORD_SIZE-1:0] dc_rdata,
    output logic                 dc_ack,
    input  logic                 dma_br,
    output logic                 dma_bg,
    input  logic                 dma_req,
    input  logic                 dma_we,
    input  logic [WORD_SIZE-1:0] dma_addr,
    input  logic [WORD_SIZE-1:0] dma_wdata,
    output logic [WORD_SIZE-1:0] dma_rdata,
    output logic                 dma_ack,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    input  logic                 mem_ack
);

    localparam logic [CNT_W-1:0] BURST_CNT = CNT_W'(DMA_BURST);

    arb_state_e           state_q,     state_d;
    logic                 mem_req_q,   mem_req_d;
    logic                 mem_we_q,    mem_we_d;
    logic [WORD_SIZE-1:0] mem_addr_q,  mem_addr_d;
    logic [WORD_SIZE-1:0] mem_wdata_q, mem_wdata_d;
    logic [WORD_SIZE-1:0] ic_rdata_q,  ic_rdata_d;
    logic [WORD_SIZE-1:0] dc_rdata_q,  dc_rdata_d;
    logic [WORD_SIZE-1:0] dma_rdata_q, dma_rdata_d;
    logic                 ic_ack_q,    ic_ack_d;
    logic                 dc_ack_q,    dc_ack_d;
    logic                 dma_ack_q,   dma_ack_d;
    logic                 dma_bg_q,    dma_bg_d;
    logic [CNT_W-1:0]     cnt_q,       cnt_d;

    owner_e               sel_s;
    logic [WORD_SIZE-1:0] sel_addr_s;
    logic                 sel_we_s;
    logic [WORD_SIZE-1:0] sel_wdata_s;

    // Who would be launched this cycle: fixed DC > IC priority in IDLE, DMA only in its own tenure
    always_comb begin
        sel_s = OWN_NONE;
        case (state_q)
            IDLE: begin
                if (dc_req) begin
                    sel_s = OWN_DC;
                end else if (ic_req) begin
                    sel_s = OWN_IC;
                end else begin
                    sel_s = OWN_NONE;
                end
            end
            DMA_OWN: begin
                sel_s = OWN_DMA;
            end
            default: begin
                sel_s = OWN_NONE;
            end
        endcase
    end

    mem_arb_mux u_mux (
        .sel       (sel_s),
        .ic_addr   (ic_addr),
        .dc_we     (dc_we),
        .dc_addr   (dc_addr),
        .dc_wdata  (dc_wdata),
        .dma_we    (dma_we),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .sel_addr  (sel_addr_s),
        .sel_we    (sel_we_s),
        .sel_wdata (sel_wdata_s)
    );

    // Next-state and next-output computation for the arbitration FSM
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        ic_rdata_d  = ic_rdata_q;
        dc_rdata_d  = dc_rdata_q;
        dma_rdata_d = dma_rdata_q;
        ic_ack_d    = 1'b0;
        dc_ack_d    = 1'b0;
        dma_ack_d   = 1'b0;
        dma_bg_d    = dma_bg_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (dc_req || ic_req) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = sel_we_s;
                    mem_addr_d  = sel_addr_s;
                    mem_wdata_d = sel_wdata_s;
                    state_d     = dc_req ? DC_XFER : IC_XFER;
                end else if (dma_br) begin
                    dma_bg_d = 1'b1;
                    cnt_d    = {CNT_W{1'b0}};
                    state_d  = DMA_OWN;
                end else begin
                    state_d = IDLE;
                end
            end
            IC_XFER: begin
                if (mem_ack) begin
                    mem_req_d  = 1'b0;
                    ic_rdata_d = mem_rdata;
                    ic_ack_d   = 1'b1;
                    state_d    = IDLE;
                end else begin
                    state_d = IC_XFER;
                end
            end
            DC_XFER: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    if (!mem_we_q) begin
                        dc_rdata_d = mem_rdata;
                    end else begin
                        dc_rdata_d = dc_rdata_q;
                    end
                    dc_ack_d = 1'b1;
                    state_d  = IDLE;
                end else begin
                    state_d = DC_XFER;
                end
            end
            DMA_OWN: begin
                if (dma_req) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = sel_we_s;
                    mem_addr_d  = sel_addr_s;
                    mem_wdata_d = sel_wdata_s;
                    state_d     = DMA_XFER;
                end else if (!dma_br) begin
                    dma_bg_d = 1'b0;
                    state_d  = IDLE;
                end else begin
                    state_d = DMA_OWN;
                end
            end
            DMA_XFER: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    if (!mem_we_q) begin
                        dma_rdata_d = mem_rdata;
                    end else begin
                        dma_rdata_d = dma_rdata_q;
                    end
                    dma_ack_d = 1'b1;
                    cnt_d     = sat_inc(cnt_q);
                    // Cache traffic only forces a release exactly at the burst boundary
                    if ((cnt_d == BURST_CNT) && (ic_req || dc_req)) begin
                        dma_bg_d = 1'b0;
                        state_d  = IDLE;
                    end else if (!dma_br) begin
                        dma_bg_d = 1'b0;
                        state_d  = IDLE;
                    end else begin
                        state_d = DMA_OWN;
                    end
                end else begin
                    state_d = DMA_XFER;
                end
            end
            default: begin
                mem_req_d = 1'b0;
                dma_bg_d  = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    // State and registered-output flops; reset abandons any word in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {WORD_SIZE{1'b0}};
            mem_wdata_q <= {WORD_SIZE{1'b0}};
            ic_rdata_q  <= {WORD_SIZE{1'b0}};
            dc_rdata_q  <= {WORD_SIZE{1'b0}};
            dma_rdata_q <= {WORD_SIZE{1'b0}};
            ic_ack_q    <= 1'b0;
            dc_ack_q    <= 1'b0;
            dma_ack_q   <= 1'b0;
            dma_bg_q    <= 1'b0;
            cnt_q       <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            ic_rdata_q  <= ic_rdata_d;
            dc_rdata_q  <= dc_rdata_d;
            dma_rdata_q <= dma_rdata_d;
            ic_ack_q    <= ic_ack_d;
            dc_ack_q    <= dc_ack_d;
            dma_ack_q   <= dma_ack_d;
            dma_bg_q    <= dma_bg_d;
            cnt_q       <= cnt_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign ic_rdata  = ic_rdata_q;
    assign dc_rdata  = dc_rdata_q;
    assign dma_rdata = dma_rdata_q;
    assign ic_ack    = ic_ack_q;
    assign dc_ack    = dc_ack_q;
    assign dma_ack   = dma_ack_q;
    assign dma_bg    = dma_bg_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: expected memory launches and acks are
// queued by the stimulus and popped by an independent monitor.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        ic_req;
    logic [15:0] ic_addr;
    logic [15:0] ic_rdata;
    logic        ic_ack;
    logic        dc_req, dc_we;
    logic [15:0] dc_addr, dc_wdata, dc_rdata;
    logic        dc_ack;
    logic        dma_br, dma_bg, dma_req, dma_we;
    logic [15:0] dma_addr, dma_wdata, dma_rdata;
    logic        dma_ack;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } mem_exp_t;

    typedef struct {
        int          port;
        logic [15:0] rdata;
    } ack_exp_t;

    mem_exp_t exp_mem[$];
    ack_exp_t exp_ack[$];

    logic [15:0] mem_model [0:255];
    int          lat = 1;
    int          mcnt = 0;

    mem_bus_arbiter #(.DMA_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_rdata(ic_rdata), .ic_ack(ic_ack),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_rdata(dc_rdata), .dc_ack(dc_ack),
        .dma_br(dma_br), .dma_bg(dma_bg), .dma_req(dma_req), .dma_we(dma_we),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Memory model: counts cycles of mem_req at the falling edge, acks after lat cycles
    always @(negedge clk) begin
        if (reset) begin
            mem_ack = 1'b0;
            mcnt    = 0;
        end else if (mem_ack) begin
            mem_ack = 1'b0;
            mcnt    = 0;
        end else if (mem_req) begin
            mcnt++;
            if (mcnt >= lat) begin
                if (mem_we) begin
                    mem_model[mem_addr[7:0]] = mem_wdata;
                    mem_rdata = 16'h0000;
                end else begin
                    mem_rdata = mem_model[mem_addr[7:0]];
                end
                mem_ack = 1'b1;
            end
        end else begin
            mcnt = 0;
        end
    end

    logic prev_mem_req = 1'b0;
    logic prev_ic_ack = 1'b0, prev_dc_ack = 1'b0, prev_dma_ack = 1'b0;

    task automatic pop_ack(input int port, input logic [15:0] rd, input logic prev, input string nm);
        ack_exp_t e;
        chk({nm, "_pulse"}, {31'd0, prev}, 32'd0);
        if (exp_ack.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_unexpected actual=ack required=none", nm);
        end else begin
            e = exp_ack.pop_front();
            chk({nm, "_port"}, port, e.port);
            chk({nm, "_rdata"}, {16'd0, rd}, {16'd0, e.rdata});
        end
    endtask

    // Monitor: checks each new memory launch and each ack against the queues
    always @(negedge clk) begin
        mem_exp_t m;
        if (!reset) begin
            if (mem_req && !prev_mem_req) begin
                if (exp_mem.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mem_unexpected actual=addr_%0h required=none", mem_addr);
                end else begin
                    m = exp_mem.pop_front();
                    chk("mem_addr", {16'd0, mem_addr}, {16'd0, m.addr});
                    chk("mem_we", {31'd0, mem_we}, {31'd0, m.we});
                    chk("mem_wdata", {16'd0, mem_wdata}, {16'd0, m.wdata});
                end
            end
            if (ic_ack)  pop_ack(0, ic_rdata, prev_ic_ack, "ic_ack");
            if (dc_ack)  pop_ack(1, dc_rdata, prev_dc_ack, "dc_ack");
            if (dma_ack) pop_ack(2, dma_rdata, prev_dma_ack, "dma_ack");
        end
        prev_mem_req = mem_req;
        prev_ic_ack  = ic_ack;
        prev_dc_ack  = dc_ack;
        prev_dma_ack = dma_ack;
    end

    function automatic logic sig_of(input int which);
        case (which)
            0: return ic_ack;
            1: return dc_ack;
            2: return dma_ack;
            3: return mem_req;
            default: return dma_bg;
        endcase
    endfunction

    // Bounded wait for a DUT output; an expired bound counts as a failure
    task automatic wait_sig(input int which, input string nm);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (sig_of(which)) return;
        end
        checks++;
        errors++;
        $display("FAIL timeout_%s actual=low required=high", nm);
    endtask

    function automatic mem_exp_t me(input logic we, input logic [15:0] a, input logic [15:0] d);
        mem_exp_t e;
        e.we = we; e.addr = a; e.wdata = d;
        return e;
    endfunction

    function automatic ack_exp_t ae(input int p, input logic [15:0] d);
        ack_exp_t e;
        e.port = p; e.rdata = d;
        return e;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < 256; i++) mem_model[i] = 16'h1000 + 16'(i);
        reset = 1'b1; mem_ack = 1'b0; mem_rdata = 16'h0000;
        ic_req = 1'b0; ic_addr = 16'h0000;
        dc_req = 1'b0; dc_we = 1'b0; dc_addr = 16'h0000; dc_wdata = 16'h0000;
        dma_br = 1'b0; dma_req = 1'b0; dma_we = 1'b0; dma_addr = 16'h0000; dma_wdata = 16'h0000;
        repeat (2) @(negedge clk);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
        chk("rst_dma_bg", {31'd0, dma_bg}, 32'd0);
        chk("rst_acks", {29'd0, ic_ack, dc_ack, dma_ack}, 32'd0);
        chk("rst_rdata", {16'd0, ic_rdata | dc_rdata | dma_rdata}, 32'd0);
        #2 reset = 1'b0;

        // 1: I-cache read, latency 3
        lat = 3;
        exp_mem.push_back(me(1'b0, 16'h0010, 16'h0000));
        exp_ack.push_back(ae(0, 16'h1010));
        @(negedge clk);
        ic_req = 1'b1; ic_addr = 16'h0010;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ic_ack) break;
            if (mem_req) n++;
        end
        ic_req = 1'b0;
        chk("ic_ack_seen", {31'd0, ic_ack}, 32'd1);
        chk("ic_mem_req_cycles", n, 32'd3);

        // 2: simultaneous DC write and IC read of the same word
        lat = 1;
        exp_mem.push_back(me(1'b1, 16'h0040, 16'hBEEF));
        exp_mem.push_back(me(1'b0, 16'h0040, 16'h0000));
        exp_ack.push_back(ae(1, 16'h0000));
        exp_ack.push_back(ae(0, 16'hBEEF));
        @(negedge clk);
        dc_req = 1'b1; dc_we = 1'b1; dc_addr = 16'h0040; dc_wdata = 16'hBEEF;
        ic_req = 1'b1; ic_addr = 16'h0040;
        wait_sig(1, "dc_ack");
        dc_req = 1'b0; dc_we = 1'b0; dc_wdata = 16'h0000;
        @(negedge clk);
        chk("ic_grant_after_dc", {31'd0, mem_req}, 32'd1);
        chk("ic_grant_addr", {16'd0, mem_addr}, 32'h0040);
        wait_sig(0, "ic_ack2");
        ic_req = 1'b0;

        // 3: DMA tenure of 12 writes, then release
        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            exp_mem.push_back(me(1'b1, 16'h01F4 + 16'(i), 16'hD000 + 16'(i)));
            exp_ack.push_back(ae(2, 16'h0000));
        end
        dma_br = 1'b1;
        @(negedge clk);
        chk("dma_bg_rise", {31'd0, dma_bg}, 32'd1);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            dma_req = 1'b1; dma_we = 1'b1;
            dma_addr = 16'h01F4 + 16'(i); dma_wdata = 16'hD000 + 16'(i);
            wait_sig(2, "dma_ack");
            if (dma_ack) n++;
            chk("dma_bg_held", {31'd0, dma_bg}, 32'd1);
        end
        dma_req = 1'b0; dma_br = 1'b0;
        chk("dma_ack_count", n, 32'd12);
        @(negedge clk);
        chk("dma_bg_release", {31'd0, dma_bg}, 32'd0);

        // 4: IC preempts DMA at the burst boundary, then DMA is regranted
        for (int i = 0; i < 4; i++) begin
            exp_mem.push_back(me(1'b1, 16'h0020 + 16'(i), 16'hA000 + 16'(i)));
            exp_ack.push_back(ae(2, 16'h0000));
        end
        exp_mem.push_back(me(1'b0, 16'h0011, 16'h0000));
        exp_ack.push_back(ae(0, 16'h1011));
        exp_mem.push_back(me(1'b1, 16'h0024, 16'hA004));
        exp_ack.push_back(ae(2, 16'h0000));
        dma_br = 1'b1;
        wait_sig(4, "dma_bg4");
        for (int i = 0; i < 4; i++) begin
            dma_req = 1'b1; dma_we = 1'b1;
            dma_addr = 16'h0020 + 16'(i); dma_wdata = 16'hA000 + 16'(i);
            wait_sig(2, "dma_ack4");
            if (i == 1) begin
                ic_req = 1'b1; ic_addr = 16'h0011;
            end
            if (i == 2) chk("no_early_preempt", {31'd0, dma_bg}, 32'd1);
        end
        dma_req = 1'b0;
        chk("preempt_bg_low", {31'd0, dma_bg}, 32'd0);
        wait_sig(0, "ic_ack4");
        ic_req = 1'b0;
        wait_sig(4, "dma_regrant");
        chk("dma_regrant", {31'd0, dma_bg}, 32'd1);
        dma_req = 1'b1; dma_addr = 16'h0024; dma_wdata = 16'hA004;
        wait_sig(2, "dma_ack5");
        dma_req = 1'b0; dma_br = 1'b0;
        @(negedge clk);

        // 5: dma_br drops while a DMA read is in flight
        lat = 3;
        exp_mem.push_back(me(1'b0, 16'h01F4, 16'h0000));
        exp_ack.push_back(ae(2, 16'hD000));
        dma_br = 1'b1;
        wait_sig(4, "dma_bg5");
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h01F4; dma_wdata = 16'h0000;
        wait_sig(3, "mem_req5");
        dma_br = 1'b0; dma_req = 1'b0;
        wait_sig(2, "dma_ack6");
        chk("br_drop_bg_low", {31'd0, dma_bg}, 32'd0);
        @(negedge clk);
        chk("br_drop_idle", {30'd0, mem_req, dma_bg}, 32'd0);

        // 6: reset in the middle of a DC read, then normal service resumes
        lat = 10;
        exp_mem.push_back(me(1'b0, 16'h0010, 16'h0000));
        dc_req = 1'b1; dc_we = 1'b0; dc_addr = 16'h0010;
        wait_sig(3, "mem_req6");
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mid_dma_bg", {31'd0, dma_bg}, 32'd0);
        dc_req = 1'b0;
        @(negedge clk);
        #2 reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_no_dc_ack", {31'd0, dc_ack}, 32'd0);
        end
        lat = 2;
        exp_mem.push_back(me(1'b0, 16'h0040, 16'h0000));
        exp_ack.push_back(ae(1, 16'hBEEF));
        dc_req = 1'b1; dc_addr = 16'h0040;
        wait_sig(1, "dc_ack7");
        dc_req = 1'b0;
        repeat (3) @(negedge clk);

        chk("exp_mem_drained", exp_mem.size(), 32'd0);
        chk("exp_ack_drained", exp_ack.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
